uart_rx_ctrl: RTL and testbench

Receive sequencer for the UART bus block. It detects a start request from the receive datapath and generates the bit-timing strobes (`baud_mid`, `baud_busy`, `baud_counte`) that make the datapath shift in eight data bits. It then checks the stop bit, captures the assembled byte and hands it downstream over a valid/ready handshake, reporting framing and overrun errors. It sits between the receive datapath (which owns `uart_din` sampling and `receive_data` assembly) and the consuming logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx_ctrl.sv | 117 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } rx_state_e;

  localparam logic [3:0] UART_BIT_START = 4'd0;
  localparam logic [3:0] UART_BIT_STOP  = 4'd9;

  localparam int unsigned UART_BAUD_DIV = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wrap strobe at the end of each bit, mid strobe at bit centre.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_en_i,
  output logic wrap_o,
  output logic mid_o
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] Last = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] Half = CntW'(BAUD_DIV >> 1);

  logic [CntW-1:0] bcnt_q, bcnt_d;

  // Counter is held at zero whenever not running, so neither strobe fires in idle.
  always_comb begin
    bcnt_d = '0;
    if (run_en_i) begin
      bcnt_d = (bcnt_q == Last) ? '0 : bcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign wrap_o = (bcnt_q == Last);
  assign mid_o  = (bcnt_q == Half);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: bit timing, stop check, holding register and error pulses.
// Optional macro UART_RX_START_CHECK_EN aborts the frame if the start bit reads high at its centre.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       receive_start,
  input  logic       uart_din,
  input  logic [7:0] receive_data,
  output logic       baud_mid,
  output logic       baud_busy,
  output logic [3:0] baud_counte,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       frame_end, good, wrap, mid, run_en;

  // Stop the bit counter on the ending edge so idle always starts from zero.
  assign run_en = (state_q == StRun) && !frame_end;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en_i (run_en),
    .wrap_o   (wrap),
    .mid_o    (mid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    frame_end   = 1'b0;
    good        = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = UART_BIT_START;
        if (receive_start) state_d = StRun;
      end
      StRun: begin
        if (mid && (cnt_q == UART_BIT_STOP)) begin
          frame_end = 1'b1;
          if (uart_din) good = 1'b1;
          else frame_err_d = 1'b1;
        end
`ifdef UART_RX_START_CHECK_EN
        else if (mid && (cnt_q == UART_BIT_START) && uart_din) begin
          frame_end = 1'b1;
        end
`endif
        else if (wrap) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (frame_end) begin
          state_d = StIdle;
          cnt_d   = UART_BIT_START;
        end
      end
      default: state_d = StIdle;
    endcase

    // A same-cycle consume frees the holding register for the new byte.
    if (good && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = receive_data;
      rx_valid_d = 1'b1;
    end else if (good) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= UART_BIT_START;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign baud_mid    = mid && (state_q == StRun);
  assign baud_busy   = (state_q == StRun);
  assign baud_counte = cnt_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (BAUD_DIV=16) with a frame-timing reference model.
module tb_uart_rx_ctrl;

  localparam int D       = 16;
  localparam int H       = D / 2;
  localparam int StopMid = 1 + 9 * D + H;

  logic       clk;
  logic       rst_n;
  logic       receive_start;
  logic       uart_din;
  logic [7:0] receive_data;
  logic       baud_mid;
  logic       baud_busy;
  logic [3:0] baud_counte;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;

  uart_rx_ctrl #(
    .BAUD_DIV (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .receive_start (receive_start),
    .uart_din      (uart_din),
    .receive_data  (receive_data),
    .baud_mid      (baud_mid),
    .baud_busy     (baud_busy),
    .baud_counte   (baud_counte),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err)
  );

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;
  int c0    = 0;
  int nmid  = 0;
  int first_mid = 0;
  int last_mid  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: frame position counted from the start request, byte hand-off rules.
  int         m_act   = 0;
  int         m_rel   = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic m_good;
    if (!rst_n) begin
      m_act = 0; m_rel = 0; m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_good = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (m_act != 0) begin
        if (m_rel == StopMid) begin
          m_act = 0;
          if (uart_din) m_good = 1'b1;
          else m_ferr = 1'b1;
        end
`ifdef UART_RX_START_CHECK_EN
        else if (m_rel == 1 + H && uart_din) m_act = 0;
`endif
        else m_rel++;
      end else if (receive_start) begin
        m_act = 1;
        m_rel = 1;
      end
      if (m_good && (!m_valid || rx_ready)) begin
        m_valid = 1'b1;
        m_data  = receive_data;
      end else if (m_good) begin
        m_ovr = 1'b1;
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic       e_busy, e_mid;
    logic [3:0] e_cnt;
    e_busy = (m_act != 0);
    e_mid  = e_busy && (((m_rel - 1) % D) == H);
    e_cnt  = e_busy ? 4'((m_rel - 1) / D) : 4'd0;
    chk("baud_busy", baud_busy, e_busy);
    chk("baud_mid", baud_mid, e_mid);
    chk("baud_counte", baud_counte, e_cnt);
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_data", rx_data, m_data);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun_err", overrun_err, m_ovr);
    if (baud_mid === 1'b1) begin
      if (nmid == 0) first_mid = cyc;
      last_mid = cyc;
      nmid++;
    end
  end

  // Drives one frame as line + datapath would; returns in the cycle after the stop centre.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic glitch,
                            input logic ready_end, input int rst_rel);
    int k, p;
    nmid = 0;
    @(posedge clk); #2;
    c0 = cyc;
    receive_start = 1'b1;
    uart_din      = 1'b0;
    for (int rel = 1; rel <= StopMid; rel++) begin
      @(posedge clk); #2;
      receive_start = 1'b0;
      p = rel - 1;
      if (p >= 1 && ((p - 1) % D) == H && (p - 1) / D >= 1 && (p - 1) / D <= 8)
        receive_data = {uart_din, receive_data[7:1]};
      k = (rel - 1) / D;
      if (k == 0) uart_din = 1'b0;
      else if (k <= 8) uart_din = b[k-1];
      else uart_din = stop_v;
      if (glitch && rel >= 3) uart_din = 1'b1;
      if (ready_end && rel == StopMid) rx_ready = 1'b1;
      if (rel == rst_rel) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", baud_busy, 1'b0);
        chk("rst_counte", baud_counte, 4'd0);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_mid", baud_mid, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n    = 1'b1;
        uart_din = 1'b1;
        return;
      end
    end
    @(posedge clk); #2;
    uart_din = 1'b1;
    if (ready_end) rx_ready = 1'b0;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(posedge clk); #2;
    rx_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    receive_start = 1'b0;
    uart_din = 1'b1;
    receive_data = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", baud_busy, 1'b0);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_counte", baud_counte, 4'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Good frame with consumer ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    chk("t1_cycle", cyc - c0, 154);
    chk("t1_valid", rx_valid, 1'b1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_busy", baud_busy, 1'b0);
    chk("t1_nmid", nmid, 10);
    chk("t1_first_mid", first_mid - c0, 9);
    chk("t1_last_mid", last_mid - c0, 153);
    @(posedge clk); #2;
    chk("t1_consumed", rx_valid, 1'b0);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_ferr", frame_err, 1'b1);
    chk("t2_valid", rx_valid, 1'b0);
    chk("t2_busy", baud_busy, 1'b0);
    @(posedge clk); #2;
    chk("t2_ferr_pulse", frame_err, 1'b0);

    // Overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    chk("t3_valid", rx_valid, 1'b1);
    chk("t3_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
    chk("t3_ovr", overrun_err, 1'b1);
    chk("t3_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(posedge clk); #2;
    chk("t3_accept", rx_valid, 1'b0);
    chk("t3_ovr_pulse", overrun_err, 1'b0);
    rx_ready = 1'b0;

    // Consume and capture on the same edge
    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_first", rx_data, 8'h66);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1, 0);
    chk("t4_valid", rx_valid, 1'b1);
    chk("t4_data", rx_data, 8'h77);
    chk("t4_no_ovr", overrun_err, 1'b0);
    drain();

    // Start-bit glitch: low for 3 cycles then high
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0);
`ifdef UART_RX_START_CHECK_EN
    chk("t5_valid", rx_valid, 1'b0);
    chk("t5_nmid", nmid, 1);
`else
    chk("t5_valid", rx_valid, 1'b1);
    chk("t5_data", rx_data, 8'hFF);
    chk("t5_nmid", nmid, 10);
`endif
    drain();

    // Reset mid-frame with a byte pending, then a clean frame
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 0);
    chk("t6_pending", rx_valid, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1 + 4 * D + 5);
    repeat (3) @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    chk("t6_valid", rx_valid, 1'b1);
    chk("t6_data", rx_data, 8'h5A);
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
